// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and digit output bundle for keypad_scanner
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       key_held;

    // master: the scanner itself; slave: keypad matrix and downstream digit accumulator
    modport master (
        input  row_in,
        output col_out,
        output digit_out,
        output digit_valid,
        output key_held
    );
    modport slave (
        output row_in,
        input  col_out,
        input  digit_out,
        input  digit_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad scanner with press/release debounce
module keypad_scanner #(
    parameter int SCAN_DIV        = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master bus
);

    if (SCAN_DIV < 4) begin : g_scan_div_check
        $error("keypad_scanner: SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_check
        $error("keypad_scanner: DEBOUNCE_CYCLES must be at least 1");
    end

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ST_SCAN     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_EMIT     = 3'd2;
    localparam logic [2:0] ST_WAIT_REL = 3'd3;
    localparam logic [2:0] ST_REL_DEB  = 3'd4;

    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [2:0]    state;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [DW-1:0] dwell_cnt;
    logic [CW-1:0] deb_cnt;
    logic [3:0]    digit_q;
    logic          valid_q;
    logic          held_q;
    logic [1:0]    low_row;
    logic          watched_row;

    // Row code for the matrix position; '*' maps to E and '#' to F
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous, pulled-up row lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= bus.row_in;
            rows_s <= rows_m;
        end
    end

    // Lowest-index active row wins when several rows are low at once
    always_comb begin
        low_row = 2'd3;
        casez (rows_s)
            4'b???0: low_row = 2'd0;
            4'b??01: low_row = 2'd1;
            4'b?011: low_row = 2'd2;
            default: low_row = 2'd3;
        endcase
    end

    assign watched_row = rows_s[row_idx];

    // Scan / debounce / emit / release-debounce sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            digit_q   <= 4'h0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (rows_s == 4'hF) begin
                            col_idx <= col_idx + 2'd1;
                        end else begin
                            row_idx <= low_row;
                            deb_cnt <= '0;
                            state   <= ST_DEBOUNCE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (watched_row) begin
                        deb_cnt   <= '0;
                        dwell_cnt <= '0;
                        col_idx   <= col_idx + 2'd1;
                        state     <= ST_SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        digit_q <= key_code(row_idx, col_idx);
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        state   <= ST_EMIT;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (watched_row) begin
                        deb_cnt <= '0;
                        state   <= ST_REL_DEB;
                    end
                end
                ST_REL_DEB: begin
                    if (!watched_row) begin
                        deb_cnt <= '0;
                        state   <= ST_WAIT_REL;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt   <= '0;
                        held_q    <= 1'b0;
                        col_idx   <= 2'd0;
                        dwell_cnt <= '0;
                        state     <= ST_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_SCAN;
                    col_idx   <= 2'd0;
                    dwell_cnt <= '0;
                    deb_cnt   <= '0;
                    held_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.col_out     = ~(4'b0001 << col_idx);
    assign bus.digit_out   = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.key_held    = held_q;

endmodule
